// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - TAP register addresses and read arbiter state type
package uart_pkg;

   localparam int IRLENGTH = 5;

   localparam logic [IRLENGTH-1:0] ADDR_NOP     = 5'h00;
   localparam logic [IRLENGTH-1:0] ADDR_IDCODE  = 5'h01;
   localparam logic [IRLENGTH-1:0] ADDR_STB0_CS = 5'h04;
   localparam logic [IRLENGTH-1:0] ADDR_STB0_D  = 5'h05;
   localparam logic [IRLENGTH-1:0] ADDR_STB1_CS = 5'h06;
   localparam logic [IRLENGTH-1:0] ADDR_STB1_D  = 5'h07;
   localparam logic [IRLENGTH-1:0] ADDR_DTMCS   = 5'h10;
   localparam logic [IRLENGTH-1:0] ADDR_DMI     = 5'h11;
   localparam logic [IRLENGTH-1:0] ADDR_BYPASS  = 5'h1F;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_HEADER,
      ST_DATA
   } arb_state_t;

endpackage

// File: rtl/tap_read_arbiter.sv
// rtl/tap_read_arbiter.sv - arbitrates host/autonomous register reads and streams result to UART
module tap_read_arbiter
   import uart_pkg::*;
#(
   parameter int READ_WIDTH     = 41,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  CLK_I,
   input  logic                  RST_I,
   input  logic                  HOST_REQ_I,
   input  logic [IRLENGTH-1:0]   HOST_ADDR_I,
   output logic                  HOST_ACK_O,
   input  logic                  AUTO_EN_I,
   input  logic [IRLENGTH-1:0]   VALID_ADDRESS_I,
   output logic [IRLENGTH-1:0]   READ_ADDRESS_O,
   output logic                  READ_READY_O,
   input  logic                  READ_VALID_I,
   input  logic [READ_WIDTH-1:0] READ_DATA_I,
   output logic [7:0]            TX_DATA_O,
   output logic                  TX_VALID_O,
   input  logic                  TX_READY_I,
   output logic                  BUSY_O
);

   localparam int NBYTES = (READ_WIDTH + 7) / 8;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

   arb_state_t          state;
   logic [IRLENGTH-1:0] addr;
   logic                err;
   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    idx;
   logic [7:0]          data_bytes [NBYTES];
   logic [NBYTES*8-1:0] rd_pad;

   // zero-extend the read word to whole bytes so the last byte is padded
   always_comb begin
      rd_pad = '0;
      rd_pad[READ_WIDTH-1:0] = READ_DATA_I;
   end

   assign BUSY_O = (state != ST_IDLE);

   // arbitration, read handshake with timeout, and header/data byte streaming
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state          <= ST_IDLE;
         addr           <= ADDR_NOP;
         err            <= 1'b0;
         cnt            <= '0;
         idx            <= '0;
         HOST_ACK_O     <= 1'b0;
         READ_ADDRESS_O <= ADDR_NOP;
         READ_READY_O   <= 1'b0;
         TX_DATA_O      <= 8'h00;
         TX_VALID_O     <= 1'b0;
         for (int i = 0; i < NBYTES; i++) data_bytes[i] <= 8'h00;
      end else begin
         HOST_ACK_O <= 1'b0;
         case (state)
            ST_IDLE: begin
               // host always wins over a simultaneous autonomous request
               if (HOST_REQ_I) begin
                  addr           <= HOST_ADDR_I;
                  HOST_ACK_O     <= 1'b1;
                  READ_ADDRESS_O <= HOST_ADDR_I;
                  READ_READY_O   <= 1'b1;
                  cnt            <= '0;
                  state          <= ST_READ;
               end else if (AUTO_EN_I && (VALID_ADDRESS_I != ADDR_NOP)) begin
                  addr           <= VALID_ADDRESS_I;
                  READ_ADDRESS_O <= VALID_ADDRESS_I;
                  READ_READY_O   <= 1'b1;
                  cnt            <= '0;
                  state          <= ST_READ;
               end
            end
            ST_READ: begin
               cnt <= cnt + 1'b1;
               if (READ_VALID_I) begin
                  for (int i = 0; i < NBYTES; i++) data_bytes[i] <= rd_pad[8*i +: 8];
                  err            <= 1'b0;
                  READ_READY_O   <= 1'b0;
                  READ_ADDRESS_O <= ADDR_NOP;
                  TX_DATA_O      <= {1'b0, 2'b00, addr};
                  TX_VALID_O     <= 1'b1;
                  state          <= ST_HEADER;
               end else if (cnt == CNT_LAST) begin
                  // abandoned read: report error with an all-zero payload
                  for (int i = 0; i < NBYTES; i++) data_bytes[i] <= 8'h00;
                  err            <= 1'b1;
                  READ_READY_O   <= 1'b0;
                  READ_ADDRESS_O <= ADDR_NOP;
                  TX_DATA_O      <= {1'b1, 2'b00, addr};
                  TX_VALID_O     <= 1'b1;
                  state          <= ST_HEADER;
               end
            end
            ST_HEADER: begin
               if (TX_READY_I) begin
                  idx       <= '0;
                  TX_DATA_O <= data_bytes[0];
                  state     <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (TX_READY_I) begin
                  if (idx == IDX_LAST) begin
                     TX_VALID_O <= 1'b0;
                     TX_DATA_O  <= 8'h00;
                     idx        <= '0;
                     state      <= ST_IDLE;
                  end else begin
                     idx       <= idx + 1'b1;
                     TX_DATA_O <= data_bytes[idx + 1'b1];
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tap_read_arbiter.sv
// tb/tb_tap_read_arbiter.sv - directed self-checking bench for tap_read_arbiter
module tb_tap_read_arbiter;
   import uart_pkg::*;

   logic        CLK_I = 1'b0;
   logic        RST_I;
   logic        HOST_REQ_I;
   logic [4:0]  HOST_ADDR_I;
   logic        HOST_ACK_O;
   logic        AUTO_EN_I;
   logic [4:0]  VALID_ADDRESS_I;
   logic [4:0]  READ_ADDRESS_O;
   logic        READ_READY_O;
   logic        READ_VALID_I;
   logic [40:0] READ_DATA_I;
   logic [7:0]  TX_DATA_O;
   logic        TX_VALID_O;
   logic        TX_READY_I;
   logic        BUSY_O;

   int errors = 0;
   int checks = 0;
   logic [7:0] got [8];
   int got_n;
   int stab_err;

   tap_read_arbiter #(.READ_WIDTH(41), .TIMEOUT_CYCLES(255)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I),
      .HOST_REQ_I(HOST_REQ_I), .HOST_ADDR_I(HOST_ADDR_I), .HOST_ACK_O(HOST_ACK_O),
      .AUTO_EN_I(AUTO_EN_I), .VALID_ADDRESS_I(VALID_ADDRESS_I),
      .READ_ADDRESS_O(READ_ADDRESS_O), .READ_READY_O(READ_READY_O),
      .READ_VALID_I(READ_VALID_I), .READ_DATA_I(READ_DATA_I),
      .TX_DATA_O(TX_DATA_O), .TX_VALID_O(TX_VALID_O), .TX_READY_I(TX_READY_I),
      .BUSY_O(BUSY_O)
   );

   always #5 CLK_I = ~CLK_I;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK_I);
      #1;
   endtask

   task automatic host_req(input logic [4:0] a);
      int c = 0;
      bit seen = 0;
      HOST_ADDR_I = a;
      HOST_REQ_I  = 1'b1;
      while (!seen && c < 50) begin
         step();
         c++;
         if (HOST_ACK_O) seen = 1;
      end
      HOST_REQ_I = 1'b0;
      check("ack_seen", 64'(seen), 64'd1);
   endtask

   task automatic collect(input int n, input bit toggle);
      int cyc = 0;
      bit pv = 0, pa = 0;
      logic [7:0] pd = 8'h00;
      got_n = 0;
      stab_err = 0;
      while (got_n < n && cyc < 1000) begin
         TX_READY_I = toggle ? cyc[0] : 1'b1;
         if (pv && !pa && (!TX_VALID_O || TX_DATA_O !== pd)) stab_err++;
         if (TX_VALID_O && TX_READY_I) begin
            got[got_n] = TX_DATA_O;
            got_n++;
         end
         pv = TX_VALID_O;
         pa = TX_VALID_O && TX_READY_I;
         pd = TX_DATA_O;
         step();
         cyc++;
      end
      TX_READY_I = 1'b1;
      check("byte_count", 64'(got_n), 64'(n));
      check("tx_stable", 64'(stab_err), 64'd0);
   endtask

   task automatic check_bytes(input string tag, input logic [7:0] e0, e1, e2, e3, e4, e5, e6);
      logic [7:0] exp [7];
      exp = '{e0, e1, e2, e3, e4, e5, e6};
      for (int i = 0; i < 7; i++) check($sformatf("%s_b%0d", tag, i), 64'(got[i]), 64'(exp[i]));
   endtask

   initial begin
      int cnt;
      int bad;
      RST_I = 1'b1; HOST_REQ_I = 1'b0; HOST_ADDR_I = ADDR_NOP; AUTO_EN_I = 1'b0;
      VALID_ADDRESS_I = ADDR_NOP; READ_VALID_I = 1'b0; READ_DATA_I = '0; TX_READY_I = 1'b1;
      step(); step();
      check("rst_ack", 64'(HOST_ACK_O), 64'd0);
      check("rst_rdy", 64'(READ_READY_O), 64'd0);
      check("rst_addr", 64'(READ_ADDRESS_O), 64'(ADDR_NOP));
      check("rst_txv", 64'(TX_VALID_O), 64'd0);
      check("rst_txd", 64'(TX_DATA_O), 64'd0);
      check("rst_busy", 64'(BUSY_O), 64'd0);
      RST_I = 1'b0;
      step();

      // host IDCODE read, data 0x1
      READ_VALID_I = 1'b1; READ_DATA_I = 41'h1;
      host_req(ADDR_IDCODE);
      check("idc_rdaddr", 64'(READ_ADDRESS_O), 64'(ADDR_IDCODE));
      check("idc_rdy", 64'(READ_READY_O), 64'd1);
      check("idc_busy", 64'(BUSY_O), 64'd1);
      collect(7, 1'b0);
      check_bytes("idc", 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      check("idc_idle", 64'(BUSY_O), 64'd0);
      step();

      // host DMI vs simultaneous auto STB0_CS
      READ_DATA_I = 41'hAB;
      AUTO_EN_I = 1'b1; VALID_ADDRESS_I = ADDR_STB0_CS;
      host_req(ADDR_DMI);
      check("arb_rdaddr", 64'(READ_ADDRESS_O), 64'(ADDR_DMI));
      collect(7, 1'b0);
      check_bytes("arb_dmi", 8'h11, 8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      collect(7, 1'b0);
      AUTO_EN_I = 1'b0; VALID_ADDRESS_I = ADDR_NOP;
      check_bytes("arb_stb", 8'h04, 8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      step();
      check("arb_idle", 64'(BUSY_O), 64'd0);

      // timeout: no read valid
      READ_VALID_I = 1'b0;
      host_req(ADDR_DMI);
      cnt = 0;
      while (READ_READY_O && cnt < 400) begin
         cnt++;
         step();
      end
      check("to_cycles", 64'(cnt), 64'd255);
      collect(7, 1'b0);
      check_bytes("to", 8'h91, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      step();

      // DMI data with toggling ready; error flag must clear
      READ_VALID_I = 1'b1; READ_DATA_I = 41'h1_2345_6789_AB;
      host_req(ADDR_DMI);
      collect(7, 1'b1);
      check_bytes("tog", 8'h11, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01);
      step();

      // reset mid-DATA at byte 3
      READ_DATA_I = 41'h0_5566_7788_99;
      host_req(ADDR_IDCODE);
      collect(4, 1'b0);
      check("mid_txd", 64'(TX_DATA_O), 64'h66);
      #2 RST_I = 1'b1;
      #1;
      check("mr_txv", 64'(TX_VALID_O), 64'd0);
      check("mr_txd", 64'(TX_DATA_O), 64'd0);
      check("mr_busy", 64'(BUSY_O), 64'd0);
      check("mr_rdy", 64'(READ_READY_O), 64'd0);
      check("mr_addr", 64'(READ_ADDRESS_O), 64'(ADDR_NOP));
      step();
      RST_I = 1'b0;
      step();
      host_req(ADDR_IDCODE);
      collect(7, 1'b0);
      check_bytes("mr_re", 8'h01, 8'h99, 8'h88, 8'h77, 8'h66, 8'h55, 8'h00);
      step();

      // auto disabled: pending valid address must be ignored
      AUTO_EN_I = 1'b0; VALID_ADDRESS_I = ADDR_STB1_D;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (READ_READY_O || TX_VALID_O || BUSY_O) bad++;
      end
      check("noauto", 64'(bad), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tap_read_arbiter.md
TAP_READ_ARBITER -- requirements
Module: tap_read_arbiter

Interface
REQ-001 Parameter READ_WIDTH, default 41, width of the read data word from the read interconnect.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, maximum wait for read valid before abort.
REQ-003 CLK_I  in  1  single clock; all state changes on its rising edge.
REQ-004 RST_I  in  1  reset; asynchronous, active-high.
REQ-005 HOST_REQ_I  in  1  host read request from UART command decoder, level until acked.
REQ-006 HOST_ADDR_I  in  IRLENGTH  register address for the host request.
REQ-007 HOST_ACK_O  out  1  one-cycle pulse when the host request is accepted.
REQ-008 AUTO_EN_I  in  1  enables autonomous reads of peripherals reporting valid data.
REQ-009 VALID_ADDRESS_I  in  IRLENGTH  address of a peripheral with pending data; ADDR_NOP = none.
REQ-010 READ_ADDRESS_O  out  IRLENGTH  address driven to the read interconnect.
REQ-011 READ_READY_O  out  1  read ready to the interconnect.
REQ-012 READ_VALID_I  in  1  read valid from the interconnect.
REQ-013 READ_DATA_I  in  READ_WIDTH  read data from the interconnect.
REQ-014 TX_DATA_O  out  8  byte to UART transmitter.
REQ-015 TX_VALID_O  out  1  byte valid to UART transmitter.
REQ-016 TX_READY_I  in  1  UART transmitter ready.
REQ-017 BUSY_O  out  1  high in every state except IDLE.

Function
REQ-018 FSM states IDLE, READ, HEADER, DATA; NBYTES = ceil(READ_WIDTH/8) (6 at default).
REQ-019 IDLE: HOST_REQ_I high -> latch HOST_ADDR_I, pulse HOST_ACK_O, go READ; host wins any simultaneous auto request.
REQ-020 IDLE: no host request, AUTO_EN_I high and VALID_ADDRESS_I != ADDR_NOP -> latch VALID_ADDRESS_I, go READ, no ack.
REQ-021 READ: READ_ADDRESS_O = latched address, READ_READY_O = 1; transfer in any cycle READ_READY_O && READ_VALID_I.
REQ-022 On transfer: latch READ_DATA_I, clear error flag, go HEADER next cycle; READ_READY_O low from that cycle.
REQ-023 Timeout counter clears on entering READ, increments each READ cycle; when it reaches TIMEOUT_CYCLES without transfer: data := 0, error flag := 1, go HEADER.
REQ-024 HEADER: TX_DATA_O = {error, 2'b00, address} (IRLENGTH = 5), TX_VALID_O = 1; on TX_READY_I go DATA with byte index 0.
REQ-025 DATA: TX_DATA_O = data byte[index], LSB byte first, upper bits of last byte zero-padded; advance on TX_VALID_O && TX_READY_I.
REQ-026 After byte NBYTES-1 accepted -> IDLE; a new request may be accepted in the cycle after returning to IDLE.
REQ-027 TX_VALID_O once raised stays high and TX_DATA_O stable until TX_READY_I.
REQ-028 HOST_REQ_I arriving while busy is held off (no ack) until IDLE; VALID_ADDRESS_I changes while busy are ignored.
REQ-029 READ_ADDRESS_O = ADDR_NOP and READ_READY_O = 0 outside READ.
REQ-030 All outputs registered or decoded from registered state only; no combinational path from TX_READY_I to TX_DATA_O.

Reset
REQ-031 RST_I high at any time forces IDLE asynchronously, aborting any read or byte stream.
REQ-032 Reset values: HOST_ACK_O 0, READ_READY_O 0, READ_ADDRESS_O ADDR_NOP, TX_VALID_O 0, TX_DATA_O 0, BUSY_O 0, counters/data/error 0.

Structure
REQ-033 IRLENGTH, ADDR_* constants and the FSM state enum type live in uart_pkg.
REQ-034 Single module, no sub-modules; timeout counter width $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-035 Host req ADDR_IDCODE, READ_VALID_I=1 with data 0x1 -> ack pulse, TX bytes 0x01,0x01,0x00,0x00,0x00,0x00,0x00.
REQ-036 Host req ADDR_DMI and VALID_ADDRESS_I=ADDR_STB0_CS same cycle, AUTO_EN_I=1 -> DMI served first, STB0_CS served afterwards.
REQ-037 Host req ADDR_DMI, READ_VALID_I held 0 -> after 255 READ cycles header 0x80|ADDR_DMI then six 0x00 bytes.
REQ-038 DMI data 0x1_2345_6789_AB with TX_READY_I toggling every other cycle -> bytes AB,89,67,45,23,01 in order, each stable until accepted.
REQ-039 RST_I asserted mid-DATA at byte 3 -> outputs at reset values immediately; next host request restarts from header.
REQ-040 AUTO_EN_I=0, VALID_ADDRESS_I=ADDR_STB1_D for 100 cycles -> no READ_READY_O, no TX traffic, BUSY_O stays 0.
